// File: rtl/led_pwm_pkg.sv
// Shared constants and helpers for the LED PWM fader.
package led_pwm_pkg;

    localparam int PWM_BITS_DEF  = 8;
    localparam int PRESCALE_DEF  = 195;
    localparam int FADE_STEP_DEF = 8;

    typedef logic [PWM_BITS_DEF-1:0] bright_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < value) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness register with saturating fade step and PWM compare flop.
// LED_PWM_ACTIVE_LOW_EN inverts the output flop (reset value 1 = LED off).
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS  = PWM_BITS_DEF,
    parameter int FADE_STEP = FADE_STEP_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                period_end,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                target,
    output logic                led,
    output logic                mismatch
);

    localparam int MAX_I  = (1 << PWM_BITS) - 1;
    localparam int STEP_I = (FADE_STEP > MAX_I) ? MAX_I : FADE_STEP;
    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam logic [PWM_BITS:0]   STEP = (PWM_BITS+1)'(STEP_I);

`ifdef LED_PWM_ACTIVE_LOW_EN
    localparam logic LED_POL = 1'b1;
`else
    localparam logic LED_POL = 1'b0;
`endif

    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic                led_q, led_d;
    logic [PWM_BITS-1:0] tgt;
    logic [PWM_BITS:0]   cur_w, tgt_w, sum_w, diff_w;

    // One extra bit keeps the step from wrapping in either direction.
    always_comb begin
        tgt    = target ? MAX : '0;
        cur_w  = {1'b0, bright_q};
        tgt_w  = {1'b0, tgt};
        sum_w  = cur_w + STEP;
        diff_w = cur_w - STEP;
        bright_d = bright_q;
        if (period_end) begin
            if (cur_w < tgt_w) begin
                bright_d = (sum_w > tgt_w) ? tgt : sum_w[PWM_BITS-1:0];
            end else if (cur_w > tgt_w) begin
                bright_d = (diff_w[PWM_BITS] || (diff_w < tgt_w)) ? tgt : diff_w[PWM_BITS-1:0];
            end
        end
        // Full brightness is forced to constant on, avoiding the one-slot dropout.
        led_d = ((bright_q == MAX) || (pwm_cnt < bright_q)) ^ LED_POL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright_q <= '0;
            led_q    <= LED_POL;
        end else begin
            bright_q <= bright_d;
            led_q    <= led_d;
        end
    end

    assign led      = led_q;
    assign mismatch = (bright_q != tgt);

endmodule

// File: rtl/led_pwm_fader.sv
// LED fader top: input register, shared prescaler/PWM counter, per-LED channels, busy flag.
// LED_PWM_ACTIVE_LOW_EN selects active-low LED drive (handled in led_pwm_channel).
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int NUM_LEDS  = 8,
    parameter int PWM_BITS  = PWM_BITS_DEF,
    parameter int PRESCALE  = PRESCALE_DEF,
    parameter int FADE_STEP = FADE_STEP_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy
);

    localparam int PRE_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);

    logic [PRE_W-1:0]    prescaler_q, prescaler_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0] target_q, target_d;
    logic                busy_q, busy_d;
    logic [NUM_LEDS-1:0] mismatch;
    logic                tick;
    logic                period_end;

    always_comb begin
        tick        = (prescaler_q == PRE_W'(PRESCALE - 1));
        period_end  = tick && (pwm_cnt_q == '1);
        prescaler_d = tick ? '0 : prescaler_q + PRE_W'(1);
        pwm_cnt_d   = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        target_d    = led_in;
        busy_d      = |mismatch;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_q <= '0;
            pwm_cnt_q   <= '0;
            target_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            pwm_cnt_q   <= pwm_cnt_d;
            target_q    <= target_d;
            busy_q      <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .period_end (period_end),
            .pwm_cnt    (pwm_cnt_q),
            .target     (target_q[i]),
            .led        (led_out[i]),
            .mismatch   (mismatch[i])
        );
    end

    assign busy = busy_q;

endmodule
